// File: rtl/interrupt_controller.sv
// N-channel vectored interrupt controller: pending latch, mask,
// fixed-priority arbitration and an ack/return handshake to the CPU.
module interrupt_controller #(
  parameter int                    NUM_CHANNELS  = 4,
  parameter int                    ADDR_WIDTH    = 20,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE   = 'h00100,
  parameter int                    VECTOR_STRIDE = 16,
  parameter bit                    EDGE_MODE     = 1'b1,
  parameter logic [NUM_CHANNELS-1:0] MASK_RESET  = '0,
  parameter int                    ID_WIDTH      = $clog2(NUM_CHANNELS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] irq_request,
  input  logic                    mask_write,
  input  logic [NUM_CHANNELS-1:0] mask_in,
  input  logic                    interrupt_ack,
  input  logic                    interrupt_return,
  output logic                    interrupt_enable,
  output logic                    interrupt_disable,
  output logic [ADDR_WIDTH-1:0]   interrupt_address,
  output logic [ID_WIDTH-1:0]     interrupt_id,
  output logic [NUM_CHANNELS-1:0] pending_out,
  output logic [NUM_CHANNELS-1:0] mask_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_t;

  state_t                  state;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] prev_request;
  logic [NUM_CHANNELS-1:0] mask;
  logic [NUM_CHANNELS-1:0] set_vec;
  logic [NUM_CHANNELS-1:0] clr_vec;
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    any_eligible;
  logic [ID_WIDTH-1:0]     win_id;
  logic [ADDR_WIDTH-1:0]   win_addr;

  always_comb begin
    if (EDGE_MODE) set_vec = irq_request & ~prev_request;
    else           set_vec = irq_request;
  end

  // Only an ack that is actually accepted retires the granted channel.
  always_comb begin
    clr_vec = '0;
    if (state == REQUEST && interrupt_ack)
      clr_vec[interrupt_id] = 1'b1;
  end

  assign eligible     = pending & ~mask;
  assign any_eligible = |eligible;

  // Scan downwards so the lowest set index is the one that sticks.
  always_comb begin
    win_id = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (eligible[i]) win_id = ID_WIDTH'(i);
  end

  assign win_addr = VECTOR_BASE
                  + ADDR_WIDTH'(win_id) * ADDR_WIDTH'(VECTOR_STRIDE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      pending           <= '0;
      prev_request      <= '0;
      mask              <= MASK_RESET;
      interrupt_enable  <= 1'b0;
      interrupt_disable <= 1'b0;
      interrupt_address <= '0;
      interrupt_id      <= '0;
    end else begin
      prev_request <= irq_request;
      pending      <= set_vec | (pending & ~clr_vec);
      if (mask_write) mask <= mask_in;
      unique case (state)
        IDLE: begin
          if (any_eligible) begin
            interrupt_id      <= win_id;
            interrupt_address <= win_addr;
            interrupt_enable  <= 1'b1;
            state             <= REQUEST;
          end
        end
        REQUEST: begin
          if (interrupt_ack) begin
            interrupt_enable  <= 1'b0;
            interrupt_disable <= 1'b1;
            state             <= SERVICE;
          end
        end
        SERVICE: begin
          if (interrupt_return) begin
            interrupt_disable <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pending_out = pending;
  assign mask_out    = mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected vectors are queued
// by the stimulus and checked by a monitor when interrupt_enable rises.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  irq_request;
  logic        mask_write;
  logic [3:0]  mask_in;
  logic        interrupt_ack;
  logic        interrupt_return;
  logic        interrupt_enable;
  logic        interrupt_disable;
  logic [19:0] interrupt_address;
  logic [1:0]  interrupt_id;
  logic [3:0]  pending_out;
  logic [3:0]  mask_out;

  interrupt_controller dut (
    .clock             (clock),
    .reset             (reset),
    .irq_request       (irq_request),
    .mask_write        (mask_write),
    .mask_in           (mask_in),
    .interrupt_ack     (interrupt_ack),
    .interrupt_return  (interrupt_return),
    .interrupt_enable  (interrupt_enable),
    .interrupt_disable (interrupt_disable),
    .interrupt_address (interrupt_address),
    .interrupt_id      (interrupt_id),
    .pending_out       (pending_out),
    .mask_out          (mask_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] addr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic en_q   = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a new vector is presented when interrupt_enable rises.
  always @(negedge clock) begin
    if (interrupt_enable === 1'b1 && en_q === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got id %0d addr 0x%0h expected none",
                 interrupt_id, interrupt_address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("vec_id", 32'(interrupt_id), 32'(e.id));
        check("vec_addr", 32'(interrupt_address), 32'(e.addr));
        check("vec_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    en_q = interrupt_enable;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_vec(input logic [1:0] id, input logic [19:0] addr,
                            input int lat);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic pulse_ack();
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    interrupt_return = 1'b1;
    step(1);
    interrupt_return = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    irq_request      = 4'b1111;
    mask_write       = 1'b0;
    mask_in          = 4'b0000;
    interrupt_ack    = 1'b0;
    interrupt_return = 1'b0;
    step(2);
    check("rst_enable", 32'(interrupt_enable), 32'd0);
    check("rst_disable", 32'(interrupt_disable), 32'd0);
    check("rst_addr", 32'(interrupt_address), 32'd0);
    check("rst_id", 32'(interrupt_id), 32'd0);
    check("rst_pending", 32'(pending_out), 32'd0);
    check("rst_mask", 32'(mask_out), 32'd0);
    irq_request = 4'b0000;
    reset       = 1'b1;
    step(2);

    // single channel 2
    irq_request = 4'b0100;
    expect_vec(2'd2, 20'h00120, 2);
    step(1);
    check("t2_pending_set", 32'(pending_out), 32'h4);
    step(1);
    irq_request = 4'b0000;
    pulse_ack();
    check("t2_disable", 32'(interrupt_disable), 32'd1);
    check("t2_enable_off", 32'(interrupt_enable), 32'd0);
    check("t2_pending_clr", 32'(pending_out), 32'd0);
    step(2);
    pulse_ret();
    check("t2_disable_off", 32'(interrupt_disable), 32'd0);
    step(2);

    // priority 1 over 3
    irq_request = 4'b1010;
    expect_vec(2'd1, 20'h00110, 2);
    step(2);
    irq_request = 4'b0000;
    pulse_ack();
    check("t3_pending", 32'(pending_out), 32'h8);
    step(1);
    pulse_ret();
    expect_vec(2'd3, 20'h00130, 1);
    step(1);
    pulse_ack();
    check("t3_pending_clr", 32'(pending_out), 32'd0);
    pulse_ret();
    step(2);

    // masking
    mask_in    = 4'b0001;
    mask_write = 1'b1;
    step(1);
    mask_write = 1'b0;
    check("t4_mask", 32'(mask_out), 32'h1);
    irq_request = 4'b0001;
    step(1);
    irq_request = 4'b0000;
    step(3);
    check("t4_masked_enable", 32'(interrupt_enable), 32'd0);
    check("t4_masked_pending", 32'(pending_out), 32'h1);
    mask_in    = 4'b0000;
    mask_write = 1'b1;
    expect_vec(2'd0, 20'h00100, 2);
    step(1);
    mask_write = 1'b0;
    step(1);
    pulse_ack();
    pulse_ret();
    step(2);

    // set wins over clear on the ack edge
    irq_request = 4'b0100;
    expect_vec(2'd2, 20'h00120, 2);
    step(2);
    irq_request = 4'b0000;
    step(1);
    interrupt_ack = 1'b1;
    irq_request   = 4'b0100;
    step(1);
    interrupt_ack = 1'b0;
    check("t5_pending_kept", 32'(pending_out), 32'h4);
    check("t5_disable", 32'(interrupt_disable), 32'd1);
    step(1);
    irq_request = 4'b0000;
    step(1);
    pulse_ret();
    expect_vec(2'd2, 20'h00120, 1);
    step(1);
    pulse_ack();
    pulse_ret();
    step(1);
    pulse_ack();
    check("t5_idle_ack_en", 32'(interrupt_enable), 32'd0);
    check("t5_idle_ack_dis", 32'(interrupt_disable), 32'd0);
    check("t5_idle_ack_pend", 32'(pending_out), 32'd0);
    step(2);

    // reset while in SERVICE
    irq_request = 4'b0001;
    expect_vec(2'd0, 20'h00100, 2);
    step(2);
    irq_request = 4'b0000;
    pulse_ack();
    irq_request = 4'b0110;
    step(1);
    check("t6_pending", 32'(pending_out), 32'h6);
    check("t6_in_service", 32'(interrupt_disable), 32'd1);
    reset       = 1'b0;
    irq_request = 4'b0000;
    step(1);
    reset = 1'b1;
    check("t6_rst_pending", 32'(pending_out), 32'd0);
    check("t6_rst_disable", 32'(interrupt_disable), 32'd0);
    check("t6_rst_enable", 32'(interrupt_enable), 32'd0);
    step(4);
    check("t6_no_dispatch", 32'(interrupt_enable), 32'd0);
    irq_request = 4'b1000;
    expect_vec(2'd3, 20'h00130, 2);
    step(2);
    irq_request = 4'b0000;
    pulse_ack();
    pulse_ret();
    step(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised N-channel vectored interrupt controller; successor to the fixed two-input interrupt priority encoder in front of the control unit.
- Latches per-channel requests as pending (edge or level mode), applies a programmable mask, and arbitrates by fixed priority (channel 0 highest).
- Presents a vector address to the memory/PC path with a request/acknowledge/return handshake.
- Holds interrupt_disable high while an ISR runs.

Parameters:
- NUM_CHANNELS, 4, number of interrupt sources (2..32).
- ADDR_WIDTH, 20, width of the vector address.
- VECTOR_BASE, 20'h00100, vector address of channel 0.
- VECTOR_STRIDE, 16, address distance between consecutive channel vectors.
- EDGE_MODE, 1, 1 = rising-edge triggered, 0 = level triggered.
- MASK_RESET, all zeros, mask value after reset (1 = channel masked).
- ID_WIDTH, $clog2(NUM_CHANNELS), width of the channel id.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- irq_request  input  NUM_CHANNELS  raw interrupt lines, already synchronous to clock.
- mask_write  input  1  when high, the mask register loads mask_in.
- mask_in  input  NUM_CHANNELS  new mask value.
- interrupt_ack  input  1  CPU accepts the presented vector (one-cycle pulse).
- interrupt_return  input  1  CPU finished the ISR (one-cycle pulse).
- interrupt_enable  output  1  vector valid / request to CPU.
- interrupt_disable  output  1  ISR in progress; blocks further dispatch.
- interrupt_address  output  ADDR_WIDTH  vector of the granted channel.
- interrupt_id  output  ID_WIDTH  granted channel number.
- pending_out  output  NUM_CHANNELS  pending register, for status reads.
- mask_out  output  NUM_CHANNELS  current mask register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State = IDLE.
  - pending = 0, prev_request = 0, mask = MASK_RESET.
  - interrupt_enable = 0, interrupt_disable = 0, interrupt_address = 0, interrupt_id = 0.
  - Reset mid-handshake aborts the handshake; no vector survives.
- Pending latch, every edge:
  - EDGE_MODE=1: set[i] = irq_request[i] & ~prev_request[i]. prev_request <= irq_request.
  - EDGE_MODE=0: set[i] = irq_request[i].
  - pending[i] <= set[i] | (pending[i] & ~clr[i]). clr[i] is 1 only for the granted id on an accepted ack.
  - Set wins over clear in the same cycle.
- Masking:
  - A masked channel still latches pending but is excluded from arbitration.
  - The mask updates on the edge where mask_write=1; the new mask is used for arbitration from the next edge.
- Arbitration: eligible = pending & ~mask. The winner is the lowest set index.
- IDLE:
  - If eligible != 0: register the winner into interrupt_id, register interrupt_address = VECTOR_BASE + id*VECTOR_STRIDE (truncated to ADDR_WIDTH), set interrupt_enable = 1, go to REQUEST.
  - Otherwise stay in IDLE.
- REQUEST:
  - Outputs are held stable. A later higher-priority request or a mask change does not alter the grant.
  - On interrupt_ack: clear pending[id], interrupt_enable = 0, interrupt_disable = 1, go to SERVICE.
- SERVICE:
  - No dispatch. On interrupt_return: interrupt_disable = 0, go to IDLE.
  - Arbitration resumes on the following edge.
- Ignored events:
  - interrupt_ack outside REQUEST and interrupt_return outside SERVICE are ignored.
  - Simultaneous ack and return are resolved by the current state only.
- Latency:
  - irq_request rises before edge k: pending is set at edge k, interrupt_enable = 1 after edge k+1 (2 cycles).
  - Ack at edge m: interrupt_disable = 1 after edge m.
  - Return at edge r: the next vector is presented after edge r+1 at the earliest.
- Level mode: a line still high after ack re-sets pending on the same edge (set wins). It is re-dispatched after return.
- Edge mode: a held-high line generates exactly one pending event.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check: reset=0 for 2 cycles with irq_request=4'b1111 → all outputs 0, pending_out=0, mask_out=MASK_RESET.
- Single channel, edge mode: irq_request[2] rises → interrupt_enable=1 two cycles later, interrupt_id=2, interrupt_address=20'h00120.
  - Ack → interrupt_disable=1 and pending_out[2]=0.
  - Return → interrupt_disable=0.
- Priority: channels 1 and 3 rise in the same cycle → id=1 served first, address 20'h00110.
  - After return → id=3, address 20'h00130.
- Masking: mask_in=4'b0001 written, then channel 0 rises → no interrupt_enable, pending_out[0]=1.
  - Write mask 0 → dispatch of id 0 two cycles later.
- Boundary, set wins: channel 2 re-edges on the ack cycle of channel 2 → pending_out[2] stays 1.
  - Channel 2 is re-dispatched after return.
  - Ack pulsed while in IDLE → no state change.
- Reset mid-operation: reset=0 while in SERVICE with pending 4'b0110 → all cleared, interrupt_disable=0.
  - No dispatch until a new edge arrives.
